// File: rtl/uart_rd_ram_pkg.sv
// Shared definitions for the UART store-and-playback block.
// Holds the RX/control state encodings, the default playback command byte,
// the frame data width and a constant log2 helper for address/counter sizing.
package uart_rd_ram_pkg;

    localparam int         FRAME_BITS     = 8;
    localparam logic [7:0] RD_CMD_DEFAULT = 8'h50;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_REARM
    } rx_state_t;

    typedef enum logic [1:0] {
        CTL_IDLE,
        CTL_RD,
        CTL_LOAD,
        CTL_WAIT
    } ctl_state_t;

    // Smallest r with 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_rd_ram_if.sv
// Byte handshake between the playback controller and the serial transmitter.
//   tx_start : 1-cycle request to send tx_data (only honoured while not busy)
//   tx_data  : byte to serialise
//   tx_busy  : high from the cycle after tx_start through the end of the stop bit
// master = controller side, slave = transmitter side.
interface uart_rd_ram_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 serial transmitter, LSB first, idle high.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   tx_if    : slave side of the byte handshake (tx_start/tx_data in, tx_busy out)
//   uart_tx  : registered serial output, forced high by reset
module uart_byte_tx
    import uart_rd_ram_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic         clk,
    input  logic         rst,
    uart_rd_ram_if.slave tx_if,
    output logic         uart_tx
);

    localparam int            CW       = clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    IDX_STOP = 4'(FRAME_BITS + 1);

    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    // shift_q[0] is always the bit currently on the line
    logic [9:0]    shift_q, shift_d;

    always_comb begin
        busy_d  = busy_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        if (!busy_q) begin
            if (tx_if.tx_start) begin
                busy_d  = 1'b1;
                cnt_d   = '0;
                idx_d   = '0;
                shift_d = {1'b1, tx_if.tx_data, 1'b0};
                tx_d    = 1'b0;
            end
        end else if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_STOP) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else begin
                idx_d   = idx_q + 4'd1;
                shift_d = {1'b1, shift_q[9:1]};
                tx_d    = shift_q[1];
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
            cnt_q  <= '0;
            idx_q  <= '0;
        end else begin
            busy_q <= busy_d;
            tx_q   <= tx_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
        end
        shift_q <= shift_d;
    end

    assign tx_if.tx_busy = busy_q;
    assign uart_tx       = tx_q;

endmodule

// File: rtl/uart_rd_ram_top.sv
// UART store-and-playback board top (SparkRoad 25 MHz).
// Received bytes are stored in a byte RAM; the command byte RD_CMD replays
// the stored bytes on uart_tx in arrival order and then empties the buffer.
// Ports:
//   ext_clk_25m : system clock
//   ext_rst_n   : synchronous reset, active HIGH despite the name
//   uart_rx     : asynchronous serial input, 8N1, idle high
//   uart_tx     : serial output, 8N1, idle high
// Optional build macro UART_RX_FRAME_CHECK_EN: discard frames whose stop bit
// samples low and wait for the line to go high before re-arming.
module uart_rd_ram_top
    import uart_rd_ram_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 217,
    parameter int         RAM_DEPTH    = 16,
    parameter logic [7:0] RD_CMD       = RD_CMD_DEFAULT
) (
    input  logic ext_clk_25m,
    input  logic ext_rst_n,
    input  logic uart_rx,
    output logic uart_tx
);

    localparam int            AW        = clog2(RAM_DEPTH);
    localparam int            CW        = clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(RAM_DEPTH);

    logic clk, rst;
    assign clk = ext_clk_25m;
    assign rst = ext_rst_n;

    // Input synchronizer; resets to the idle level so an undriven line reads idle.
    logic rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;

    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_q, rx_valid_d;

    ctl_state_t    ctl_state_q, ctl_state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d, remain_q, remain_d;
    logic          ram_we, tx_start, tx_busy;
    logic [7:0]    ram_rdata_q, ram_rdata_d;
    logic [7:0]    mem [RAM_DEPTH];

    always_comb begin
        rx_meta_d  = uart_rx;
        rx_sync_d  = rx_meta_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (!rx_sync_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = '0;
            end
            // Re-check at mid start bit; a high line here was a glitch.
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                if (rx_bit_q == 3'(FRAME_BITS - 1)) rx_state_d = RX_STOP;
                else rx_bit_d = rx_bit_q + 3'd1;
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
`ifdef UART_RX_FRAME_CHECK_EN
                if (rx_sync_q) begin
                    rx_valid_d = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_REARM;
                end
`else
                rx_valid_d = 1'b1;
                rx_state_d = RX_IDLE;
`endif
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
            RX_REARM: if (rx_sync_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        ctl_state_d = ctl_state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        remain_d    = remain_q;
        ram_we      = 1'b0;
        tx_start    = 1'b0;
        ram_rdata_d = mem[rd_ptr_q];
        case (ctl_state_q)
            CTL_IDLE: if (rx_valid_q) begin
                if (rx_shift_q == RD_CMD) begin
                    if (count_q != '0) begin
                        // Oldest byte sits count entries behind the write pointer.
                        rd_ptr_d    = wr_ptr_q - count_q[AW-1:0];
                        remain_d    = count_q;
                        ctl_state_d = CTL_RD;
                    end
                end else if (count_q != FULL) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + (AW + 1)'(1);
                end
            end
            CTL_RD:   ctl_state_d = CTL_LOAD;
            CTL_LOAD: begin
                tx_start    = 1'b1;
                ctl_state_d = CTL_WAIT;
            end
            CTL_WAIT: if (!tx_busy) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                remain_d = remain_q - (AW + 1)'(1);
                if (remain_q == (AW + 1)'(1)) begin
                    count_d     = '0;
                    ctl_state_d = CTL_IDLE;
                end else begin
                    ctl_state_d = CTL_RD;
                end
            end
            default: ctl_state_d = CTL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_valid_q  <= 1'b0;
            ctl_state_q <= CTL_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remain_q    <= '0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_valid_q  <= rx_valid_d;
            ctl_state_q <= ctl_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remain_q    <= remain_d;
        end
        rx_shift_q  <= rx_shift_d;
        ram_rdata_q <= ram_rdata_d;
        if (ram_we) mem[wr_ptr_q] <= rx_shift_q;
    end

    uart_rd_ram_if tx_if ();

    assign tx_if.tx_start = tx_start;
    assign tx_if.tx_data  = ram_rdata_q;
    assign tx_busy        = tx_if.tx_busy;

    uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .tx_if   (tx_if),
        .uart_tx (uart_tx)
    );

endmodule

// File: tb/tb_uart_rd_ram_top.sv
// Directed bench for uart_rd_ram_top with CLKS_PER_BIT=4 and a 40 ns clock.
// A line monitor decodes every frame seen on uart_tx into queues.
module tb_uart_rd_ram_top;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int low_cnt = 0;

    logic [7:0] mon_q[$];
    bit         mon_err_q[$];
    int         mon_t_q[$];

    always #20 clk = ~clk;

    uart_rd_ram_top #(.CLKS_PER_BIT(CPB), .RAM_DEPTH(16), .RD_CMD(8'h50)) dut (
        .ext_clk_25m (clk),
        .ext_rst_n   (rst),
        .uart_rx     (rx),
        .uart_tx     (tx)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tx !== 1'b1) low_cnt = low_cnt + 1;

    // Frame decoder: first negedge with tx low is 0.5 clk into the start bit.
    initial begin : monitor
        logic [7:0] d;
        logic ok;
        int t0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                t0 = cyc;
                repeat (2) @(negedge clk);
                ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
                mon_q.push_back(d);
                mon_err_q.push_back(!ok);
                mon_t_q.push_back(t0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (mon_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic clear_mon();
        mon_q.delete();
        mon_err_q.delete();
        mon_t_q.delete();
    endtask

    task automatic test_reset();
        rx  = 1'b1;
        rst = 1'b1;
        tick(5);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b expected 1", tx);
        end
        rst = 1'b0;
        clear_mon();
        low_cnt = 0;
        tick(1000);
        checks++;
        if (low_cnt != 0) begin
            errors++;
            $display("FAIL reset_idle_line: low samples %0d expected 0", low_cnt);
        end
        checks++;
        if (mon_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_frames: got %0d frames expected 0", mon_q.size());
        end
    endtask

    task automatic test_playback();
        logic [7:0] exp_b[3];
        int gap;
        exp_b = '{8'h41, 8'h42, 8'h43};
        clear_mon();
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h43, 1'b1);
        send_byte(8'h50, 1'b1);
        wait_frames(3, 1000);
        tick(100);
        checks++;
        if (mon_q.size() != 3) begin
            errors++;
            $display("FAIL playback_count: got %0d frames expected 3", mon_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (mon_q[i] !== exp_b[i] || mon_err_q[i]) begin
                    errors++;
                    $display("FAIL playback_byte%0d: got %h (framing err %0d) expected %h",
                             i, mon_q[i], mon_err_q[i], exp_b[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                gap = mon_t_q[i] - mon_t_q[i-1];
                checks++;
                if (gap < 10 * CPB || gap > 10 * CPB + 3) begin
                    errors++;
                    $display("FAIL playback_spacing%0d: got %0d clocks expected 40..43", i, gap);
                end
            end
        end
    endtask

    task automatic test_empty_cmd();
        int lc;
        clear_mon();
        lc = low_cnt;
        send_byte(8'h50, 1'b1);
        tick(150);
        checks++;
        if (low_cnt != lc || mon_q.size() != 0) begin
            errors++;
            $display("FAIL empty_cmd: got %0d low samples, %0d frames expected 0, 0",
                     low_cnt - lc, mon_q.size());
        end
    endtask

    task automatic test_overflow();
        int bad;
        clear_mon();
        for (int i = 0; i < 18; i++) send_byte(8'(i), 1'b1);
        send_byte(8'h50, 1'b1);
        wait_frames(16, 2000);
        tick(200);
        checks++;
        if (mon_q.size() != 16) begin
            errors++;
            $display("FAIL overflow_count: got %0d frames expected 16", mon_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (mon_q[i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL overflow_byte%0d: got %h expected %h", i, mon_q[i], 8'(i));
                end
                if (mon_err_q[i]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL overflow_framing: got %0d bad frames expected 0", bad);
            end
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(20);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h50, 1'b1);
        wait_frames(1, 400);
        tick(100);
        checks++;
        if (mon_q.size() != 1) begin
            errors++;
            $display("FAIL glitch_count: got %0d frames expected 1", mon_q.size());
        end else begin
            checks++;
            if (mon_q[0] !== 8'h5A) begin
                errors++;
                $display("FAIL glitch_byte: got %h expected 5a", mon_q[0]);
            end
        end
    endtask

    task automatic test_frame_check();
        clear_mon();
        send_byte(8'h33, 1'b0);
        tick(10);
        send_byte(8'h50, 1'b1);
        wait_frames(1, 400);
        tick(100);
`ifdef UART_RX_FRAME_CHECK_EN
        checks++;
        if (mon_q.size() != 0) begin
            errors++;
            $display("FAIL frame_check_drop: got %0d frames expected 0", mon_q.size());
        end
`else
        checks++;
        if (mon_q.size() != 1) begin
            errors++;
            $display("FAIL frame_check_accept_count: got %0d frames expected 1", mon_q.size());
        end else begin
            checks++;
            if (mon_q[0] !== 8'h33) begin
                errors++;
                $display("FAIL frame_check_accept_byte: got %h expected 33", mon_q[0]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid_playback();
        int k;
        int lc;
        clear_mon();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h50, 1'b1);
        k = 0;
        while (tx !== 1'b0 && k < 500) begin
            tick(1);
            k++;
        end
        checks++;
        if (k >= 500) begin
            errors++;
            $display("FAIL midreset_start: playback never began within 500 clocks");
        end
        tick(10);
        rst = 1'b1;
        tick(1);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL midreset_tx: got %b expected 1", tx);
        end
        rst = 1'b0;
        tick(60);
        clear_mon();
        lc = low_cnt;
        tick(400);
        checks++;
        if (low_cnt != lc || mon_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d low samples, %0d frames expected 0, 0",
                     low_cnt - lc, mon_q.size());
        end
        send_byte(8'h50, 1'b1);
        tick(150);
        checks++;
        if (low_cnt != lc) begin
            errors++;
            $display("FAIL midreset_cleared: got %0d low samples expected 0", low_cnt - lc);
        end
    endtask

    initial begin
        test_reset();
        test_playback();
        test_empty_cmd();
        test_overflow();
        test_glitch();
        test_frame_check();
        test_reset_mid_playback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
